// File: rtl/bsg_fsb_node_trace_replay.sv
// ---------------------------------------------------------------------------
// bsg_fsb_node_trace_replay
//
// Purpose:
//   Replays a trace of instructions from an external combinational ROM.
//   Each ROM word carries a 4-bit opcode above a ring_width_p-bit payload.
//   The trace can send packets, receive packets and compare them against an
//   expected payload, wait on a loadable cycle counter, and stop. Packet
//   mismatches and illegal opcodes raise a sticky error flag.
//
// Ports:
//   clk_i       in   1                 single clock, all state on rising edge
//   reset_i     in   1                 synchronous, active-high reset
//   en_i        in   1                 global enable (no handshake / retire when 0)
//   v_i         in   1                 incoming packet valid
//   data_i      in   ring_width_p      incoming packet data
//   ready_o     out  1                 ready to accept an incoming packet
//   v_o         out  1                 outgoing packet valid
//   data_o      out  ring_width_p      outgoing packet data
//   yumi_i      in   1                 consumer accepted data_o this cycle
//   rom_addr_o  out  rom_addr_width_p  address of the current trace instruction
//   rom_data_i  in   ring_width_p+4    ROM word at rom_addr_o
//   done_o      out  1                 trace finished
//   error_o     out  1                 sticky mismatch / illegal-opcode flag
// ---------------------------------------------------------------------------
module bsg_fsb_node_trace_replay #(
    parameter int ring_width_p     = 32,
    parameter int rom_addr_width_p = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,

    input  logic                        v_i,
    input  logic [ring_width_p-1:0]     data_i,
    output logic                        ready_o,

    output logic                        v_o,
    output logic [ring_width_p-1:0]     data_o,
    input  logic                        yumi_i,

    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [ring_width_p+3:0]     rom_data_i,

    output logic                        done_o,
    output logic                        error_o
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_SEND   = 4'd1;
    localparam logic [3:0] OP_RECV   = 4'd2;
    localparam logic [3:0] OP_DONE   = 4'd3;
    localparam logic [3:0] OP_FINISH = 4'd4;
    localparam logic [3:0] OP_LOAD   = 4'd5;
    localparam logic [3:0] OP_WAIT   = 4'd6;

    localparam logic [rom_addr_width_p-1:0] ADDR_ONE = rom_addr_width_p'(1);
    localparam logic [ring_width_p-1:0]     CTR_ONE  = ring_width_p'(1);

    state_t                        state_r, state_n;
    logic [rom_addr_width_p-1:0]   addr_r, addr_n;
    logic [ring_width_p-1:0]       counter_r, counter_n;
    logic                          error_r, error_n;

    logic [3:0]                    opcode;
    logic [ring_width_p-1:0]       payload;
    logic [rom_addr_width_p-1:0]   addr_next;

    assign opcode    = rom_data_i[ring_width_p+3:ring_width_p];
    assign payload   = rom_data_i[ring_width_p-1:0];
    assign addr_next = addr_r + ADDR_ONE;

    assign rom_addr_o = addr_r;
    assign done_o     = (state_r == DONE);
    assign error_o    = error_r;

    // State register. Reset aborts whatever instruction is in flight and
    // restarts the trace at address 0 with a clean error flag and counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= RUN;
            addr_r    <= '0;
            counter_r <= '0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_n;
            addr_r    <= addr_n;
            counter_r <= counter_n;
            error_r   <= error_n;
        end
    end

    // Instruction decode. Every state change is gated by en_i so that a
    // disabled node neither retires nor advances the cycle counter. The
    // handshake outputs are masked during reset and outside RUN so that
    // stray v_i / yumi_i activity on other opcodes has no effect.
    always_comb begin
        state_n   = state_r;
        addr_n    = addr_r;
        counter_n = counter_r;
        error_n   = error_r;
        v_o       = 1'b0;
        ready_o   = 1'b0;
        data_o    = payload;

        if (state_r == RUN && !reset_i) begin
            case (opcode)
                OP_NOP: begin
                    if (en_i) addr_n = addr_next;
                end
                OP_SEND: begin
                    v_o = en_i;
                    if (en_i && yumi_i) addr_n = addr_next;
                end
                OP_RECV: begin
                    ready_o = en_i;
                    if (en_i && v_i) begin
                        if (data_i != payload) error_n = 1'b1;
                        addr_n = addr_next;
                    end
                end
                OP_DONE, OP_FINISH: begin
                    if (en_i) state_n = DONE;
                end
                OP_LOAD: begin
                    if (en_i) begin
                        counter_n = payload;
                        addr_n    = addr_next;
                    end
                end
                OP_WAIT: begin
                    // Retires on the cycle the counter is already zero, so
                    // a load of N makes the wait occupy N+1 cycles.
                    if (en_i) begin
                        if (counter_r == '0) addr_n = addr_next;
                        else                 counter_n = counter_r - CTR_ONE;
                    end
                end
                default: begin
                    if (en_i) begin
                        error_n = 1'b1;
                        state_n = DONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_fsb_node_trace_replay.sv
// ---------------------------------------------------------------------------
// tb_bsg_fsb_node_trace_replay
//
// Directed bench for the trace replay node. A small ROM array inside the
// bench supplies rom_data_i combinationally from the low address bits.
// ---------------------------------------------------------------------------
module tb_bsg_fsb_node_trace_replay;

    localparam int RW = 32;
    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          en;
    logic          v_in;
    logic [RW-1:0] data_in;
    logic          ready;
    logic          v_out;
    logic [RW-1:0] data_out;
    logic          yumi;
    logic [AW-1:0] rom_addr;
    logic [RW+3:0] rom_data;
    logic          done;
    logic          error;

    logic [RW+3:0] rom [0:7];

    int checkCount = 0;
    int passCount  = 0;
    int cycles;

    assign rom_data = rom[rom_addr[2:0]];

    bsg_fsb_node_trace_replay #(
        .ring_width_p     (RW),
        .rom_addr_width_p (AW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .en_i       (en),
        .v_i        (v_in),
        .data_i     (data_in),
        .ready_o    (ready),
        .v_o        (v_out),
        .data_o     (data_out),
        .yumi_i     (yumi),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .done_o     (done),
        .error_o    (error)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Drives all inputs 1ns after a rising edge, then lets logic settle.
    task automatic applyStimulus(input logic r, input logic e, input logic v,
                                 input logic [RW-1:0] d, input logic y);
        reset   = r;
        en      = e;
        v_in    = v;
        data_in = d;
        yumi    = y;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 8; i++) rom[i] = '0;
    endtask

    // Counts rising edges until rom_addr leaves 'from', bounded at 20.
    task automatic waitAddrChange(input logic [AW-1:0] from, output int n);
        n = 0;
        while (rom_addr == from && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Send 5, receive 0x20 matching, then done.
        clearRom();
        rom[0] = {4'd1, 32'h5};
        rom[1] = {4'd2, 32'h20};
        rom[2] = {4'd3, 32'h0};
        resetDut();
        checkOutput("rst_addr",  rom_addr, 0);
        checkOutput("rst_done",  done,     0);
        checkOutput("rst_error", error,    0);
        checkOutput("rst_v_mask", v_out,   0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("send_v",    v_out,    1);
        checkOutput("send_data", data_out, 5);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
        checkOutput("recv_addr",  rom_addr, 1);
        checkOutput("recv_ready", ready,    1);
        checkOutput("recv_v_out", v_out,    0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("match_addr",  rom_addr, 2);
        checkOutput("match_error", error,    0);
        checkOutput("match_done",  done,     0);
        tick();
        checkOutput("done_flag",  done,     1);
        checkOutput("done_addr",  rom_addr, 2);
        checkOutput("done_ready", ready,    0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
        tick();
        checkOutput("done_frozen", rom_addr, 2);
        checkOutput("done_v_out",  v_out,    0);

        // Receive mismatch: expected 8, got 9.
        clearRom();
        rom[0] = {4'd2, 32'h8};
        rom[1] = {4'd3, 32'h0};
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h9, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("mis_error", error,    1);
        checkOutput("mis_addr",  rom_addr, 1);
        tick();
        checkOutput("mis_done",   done,  1);
        checkOutput("mis_sticky", error, 1);

        // Send with yumi withheld 4 cycles.
        clearRom();
        rom[0] = {4'd1, 32'hAB};
        rom[1] = {4'd3, 32'h0};
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold_v",    v_out,    1);
            checkOutput("hold_data", data_out, 32'hAB);
            checkOutput("hold_addr", rom_addr, 0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("yumi_addr", rom_addr, 1);

        // Enable low for 3 cycles during a send.
        clearRom();
        rom[0] = {4'd1, 32'h77};
        rom[1] = {4'd3, 32'h0};
        resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("en_v",    v_out,    0);
            checkOutput("en_addr", rom_addr, 0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkOutput("en_v_back", v_out,    1);
        checkOutput("en_data",   data_out, 32'h77);
        tick();
        checkOutput("en_retire", rom_addr, 1);

        // Counter load 3 / wait, load 0 / wait, done.
        clearRom();
        rom[0] = {4'd5, 32'h3};
        rom[1] = {4'd6, 32'h0};
        rom[2] = {4'd5, 32'h0};
        rom[3] = {4'd6, 32'h0};
        rom[4] = {4'd3, 32'h0};
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        checkOutput("load_addr", rom_addr, 1);
        waitAddrChange(1, cycles);
        checkOutput("wait3_cycles", cycles, 4);
        checkOutput("wait3_addr",   rom_addr, 2);
        tick();
        waitAddrChange(3, cycles);
        checkOutput("wait0_cycles", cycles, 1);
        checkOutput("wait0_done",   done,   0);
        tick();
        checkOutput("wait_done", done, 1);

        // Nop, then illegal opcode, then reset recovery.
        clearRom();
        rom[0] = {4'd0, 32'h0};
        rom[1] = {4'hF, 32'h0};
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
        tick();
        checkOutput("nop_addr", rom_addr, 1);
        tick();
        checkOutput("ill_error", error,    1);
        checkOutput("ill_done",  done,     1);
        checkOutput("ill_addr",  rom_addr, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        tick();
        checkOutput("rec_error", error,    0);
        checkOutput("rec_done",  done,     0);
        checkOutput("rec_addr",  rom_addr, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
